// File: rtl/rr_arbiter4_if.sv
// rr_arbiter4_if -- request/grant bundle between the requesters and the
// round-robin arbiter.
//   req       [3:0] request vector, bit i = requester i
//   done            current owner has finished with the resource
//   gnt       [3:0] one-hot grant
//   gnt_idx   [1:0] encoded index of the granted requester
//   gnt_valid       high while gnt is non-zero
//   timeout         one-cycle pulse when a grant is force-released
// master: requester side (drives req/done); slave: arbiter side.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- round-robin arbiter sharing one resource among 4 requesters.
// The owner keeps the grant until it signals done or drops its request; every
// handoff passes through one dead RELEASE cycle and one IDLE arbitration cycle.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  rr_arbiter4_if.slave (req, done in; gnt, gnt_idx, gnt_valid, timeout out)
// Parameters:
//   MAX_HOLD  maximum grant length in cycles (2..255), used with ARB_TIMEOUT_EN
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
// Optional feature macro: ARB_TIMEOUT_EN -- when defined, a grant held for
// MAX_HOLD cycles is force-released and timeout pulses for one cycle.
// When undefined, no counter is built and timeout is tied low.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  rr_arbiter4_if.slave        bus
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
    $error("rr_arbiter4: MAX_HOLD must be 2..255 and fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_idx;
  logic       r_gnt_valid;

  logic [1:0] w_win_idx;
  logic       w_found;
  logic       w_release;

  // Scan from farthest to nearest candidate after r_ptr so the last hit,
  // i.e. the nearest set bit going round from ptr+1, is the winner.
  always_comb begin
    logic [1:0] cand;
    w_win_idx = 2'd0;
    w_found   = 1'b0;
    cand      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = r_ptr + 2'(k + 1);
      if (bus.req[cand]) begin
        w_win_idx = cand;
        w_found   = 1'b1;
      end
    end
  end

  assign w_release = bus.done | ~bus.req[r_gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_timeout;
  logic             w_expire;

  assign w_expire    = (r_hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign bus.timeout = r_timeout;
`else
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd3;
      r_gnt       <= 4'b0000;
      r_gnt_idx   <= 2'd0;
      r_gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt  <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt       <= 4'b0001 << w_win_idx;
            r_gnt_idx   <= w_win_idx;
            r_gnt_valid <= 1'b1;
            r_state     <= S_GRANT;
`ifdef ARB_TIMEOUT_EN
            r_hold_cnt  <= '0;
`endif
          end
        end
        S_GRANT: begin
          // A normal release wins over a coincident timeout.
          if (w_release) begin
            r_gnt       <= 4'b0000;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_gnt_idx;
            r_state     <= S_RELEASE;
`ifdef ARB_TIMEOUT_EN
          end else if (w_expire) begin
            r_gnt       <= 4'b0000;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_gnt_idx;
            r_state     <= S_RELEASE;
            r_timeout   <= 1'b1;
          end else begin
            r_hold_cnt  <= r_hold_cnt + CNT_W'(1);
`endif
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin arbiter sharing one resource among 4 requesters.
- Output is a registered one-hot grant plus a 2-bit encoded index. The index uses the team's 4-to-2 mapping: 0001->00, 0010->01, 0100->10, 1000->11.
- Sits in front of a shared datapath. The granted requester owns the resource until it signals done, drops its request, or (optionally) times out.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held. Used only with ARB_TIMEOUT_EN. Legal range 2..255.
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i.
- done  input  1  current owner finished; sampled only in GRANT.
- gnt  output  4  one-hot grant, registered.
- gnt_idx  output  2  encoded index of the granted requester, registered.
- gnt_valid  output  1  high while gnt is non-zero.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0.
  - state=IDLE, ptr=3. Requester 0 therefore has first priority after reset.
  - hold_cnt=0.
- Reset applies in any state, including mid-grant. Outputs are cleared by the edge at which rst is sampled high.
- Three states: IDLE, GRANT, RELEASE.
- IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise search req starting at (ptr+1) mod 4 and wrapping. The first set bit wins.
  - Next edge: gnt=onehot(win), gnt_idx=win, gnt_valid=1, state=GRANT, hold_cnt=0.
  - Latency: request sampled at edge N; grant visible from edge N.
- GRANT:
  - gnt, gnt_idx and gnt_valid hold steady.
  - Release condition: done=1, or req[gnt_idx]=0.
  - On release, next edge: gnt=0000, gnt_valid=0, ptr=gnt_idx, state=RELEASE. gnt_idx keeps its last value.
  - Changes to other req bits are ignored while in GRANT.
- RELEASE:
  - One dead cycle with no grant, so the resource sees a clean handoff.
  - Next edge: state=IDLE unconditionally.
  - Minimum re-grant spacing is therefore 2 cycles with gnt=0 between owners (RELEASE, then IDLE arbitration).
- done in IDLE or RELEASE is ignored.
- done and req drop in the same cycle: a single release; no double action.
- Single requester asserting continuously: it is re-granted after each RELEASE+IDLE gap. Round-robin never starves it, since there are no competitors.
- Wrap-around: ptr=3 means the search starts at 0.
- gnt is always zero or one-hot. gnt_valid == |gnt at all times.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt increments every cycle in GRANT.
  - If no release occurs and hold_cnt==MAX_HOLD-1, the next edge force-releases exactly like a normal release, and timeout=1 for that one cycle (the RELEASE cycle). ptr updates as in a normal release.
  - If a normal release and the timeout coincide, the normal release takes priority and timeout stays 0.
  - The grant lasts at most MAX_HOLD cycles.
- Not defined:
  - No counter is built and timeout is tied to 0.
  - A grant lasts until done or the request drops.

Test Plan:
- Reset, then req=0101 -> next edge gnt=0001, gnt_idx=00, gnt_valid=1. Pulse done -> gnt=0000 for 2 cycles, then gnt=0100, gnt_idx=10.
- req=1111 held, done pulsed 1 cycle after each grant -> grant order 0,1,2,3,0. gnt_idx sequence 00,01,10,11,00. Never two bits set in gnt.
- Owner 2 granted, req[2] drops with no done -> release, ptr=2. With req=1001 pending, the next grant is 3 (gnt=1000), not 0.
- With ARB_TIMEOUT_EN and MAX_HOLD=8, req=0010 held and done never asserted -> gnt=0010 for exactly 8 cycles, then gnt=0000 with timeout=1 for one cycle. Without the macro, the grant persists past 20 cycles and timeout stays 0.
- rst asserted mid-GRANT (owner 3) -> next edge all outputs zero, state IDLE. With req=1001, the next grant is 0 (ptr reset to 3).
- done pulsed while req=0000 in IDLE -> no state change, gnt stays 0000, timeout 0.
